// File: rtl/addition_scheduler_pkg.sv
// addition_scheduler_pkg: FSM state encoding and default sizing for the addition scheduler.
package addition_scheduler_pkg;
    localparam int BW_DEF   = 16;
    localparam int NREQ_DEF = 4;
    localparam int TMO_DEF  = 64;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/addition_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starting just after the last grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            vld
);
    int best;
    always_comb begin
        best = NREQ;
        idx  = '0;
        vld  = |req;
        gnt  = '0;
        // distance from last grant: 0 is the highest priority slot
        for (int j = 0; j < NREQ; j++) begin
            if (req[j] && ((j + NREQ - 1 - int'(last)) % NREQ) < best) begin
                best = (j + NREQ - 1 - int'(last)) % NREQ;
                idx  = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) gnt[j] = vld && (idx == IW'(j));
    end
endmodule

// File: rtl/addition_scheduler.sv
// addition_scheduler: shares one operator among NREQ requesters with round-robin grant and WAIT timeout.
module addition_scheduler
    import addition_scheduler_pkg::*;
#(
    parameter int BW   = BW_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*BW-1:0] a_bus,
    input  logic [NREQ*BW-1:0] b_bus,
    output logic [NREQ-1:0] ack,
    output logic [BW-1:0]   res_out,
    output logic            err,
    output logic            busy,
    output logic            op_st,
    output logic [BW-1:0]   op_in0,
    output logic [BW-1:0]   op_in1,
    input  logic            op_rd,
    input  logic [BW-1:0]   op_res
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO + 1);

    logic [1:0]      state;
    logic [IW-1:0]   last, gidx, a_idx;
    logic [NREQ-1:0] goh, a_gnt;
    logic [CW-1:0]   cnt;
    logic            err_q, a_vld;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req  (req),
        .last (last),
        .gnt  (a_gnt),
        .idx  (a_idx),
        .vld  (a_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last    <= IW'(NREQ - 1);
            gidx    <= '0;
            goh     <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            res_out <= '0;
            op_in0  <= '0;
            op_in1  <= '0;
        end else begin
            case (state)
                S_IDLE: if (a_vld) begin
                    gidx   <= a_idx;
                    goh    <= a_gnt;
                    op_in0 <= a_bus[int'(a_idx)*BW +: BW];
                    op_in1 <= b_bus[int'(a_idx)*BW +: BW];
                    state  <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt holds the number of WAIT cycles already spent without a result
                    if (op_rd) begin
                        res_out <= op_res;
                        err_q   <= 1'b0;
                        state   <= S_DONE;
                    end else if (cnt == CW'(TMO - 1)) begin
                        res_out <= '0;
                        err_q   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    last  <= gidx;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack   = (state == S_DONE) ? goh : '0;
    assign err   = (state == S_DONE) && err_q;
    assign busy  = state != S_IDLE;
    assign op_st = state == S_ISSUE;
endmodule

// File: tb/tb_addition_scheduler.sv
// tb_addition_scheduler: randomized and directed scoreboard bench with a behavioural operator and round-robin model.
module tb_addition_scheduler;
    localparam int BW = 16, NREQ = 4, TMO = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*BW-1:0] a_bus = '0, b_bus = '0;
    logic [NREQ-1:0] ack;
    logic [BW-1:0] res_out, op_in0, op_in1;
    logic [BW-1:0] op_res = '0;
    logic err, busy, op_st;
    logic op_rd = 1'b0;

    addition_scheduler #(.BW(BW), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .res_out(res_out), .err(err), .busy(busy), .op_st(op_st),
        .op_in0(op_in0), .op_in1(op_in1), .op_rd(op_rd), .op_res(op_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [BW-1:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_fail = 0;
    int dly_cfg = -1;
    int model_last = NREQ - 1;
    int ack_cnt[NREQ];
    int n_st = 0, n_ack = 0;
    logic [BW-1:0] av[NREQ], bv[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // round-robin rule: first pending requester after the previous winner
    function automatic int pick(input logic [NREQ-1:0] m, input int last);
        for (int o = 1; o <= NREQ; o++)
            if (m[(last + o) % NREQ]) return (last + o) % NREQ;
        return -1;
    endfunction

    task automatic push_exp(input int i, input logic [BW-1:0] r, input logic e);
        exp_t x;
        x.idx = i; x.res = r; x.err = e;
        sb.push_back(x);
        model_last = i;
    endtask

    task automatic set_ops(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
        av[i] = a; bv[i] = b;
        a_bus[i*BW +: BW] = a;
        b_bus[i*BW +: BW] = b;
    endtask

    task automatic push_batch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] m;
        logic [BW-1:0] s;
        int i;
        m = mask;
        while (m != 0) begin
            i = pick(m, model_last);
            s = av[i] + bv[i];
            push_exp(i, s, 1'b0);
            m[i] = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int budget = 3000;
        while ((req != 0 || busy) && budget > 0) begin
            @(negedge clk);
            req &= ~ack;
            budget--;
        end
        check({name, "_finished"}, budget > 0, 1);
        check({name, "_drained"}, sb.size(), 0);
    endtask

    task automatic wait_st();
        int b = 100;
        while (!op_st && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("st_seen", op_st, 1);
    endtask

    task automatic run_batch(input logic [NREQ-1:0] mask, input int dly, input string name);
        dly_cfg = dly;
        push_batch(mask);
        req = mask;
        wait_done(name);
    endtask

    // shared operator: result after dly_cfg cycles (random when negative, never when zero)
    initial begin
        int pend = 0;
        forever begin
            @(negedge clk);
            #1;
            op_rd = 1'b0;
            if (op_st) pend = (dly_cfg < 0) ? int'($urandom_range(1, 6)) : dly_cfg;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    op_rd  = 1'b1;
                    op_res = op_in0 + op_in1;
                end
            end
        end
    end

    // monitor: pops the scoreboard on every ACK
    initial begin
        int since = 0;
        logic prev_st = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (op_st) begin
                n_st++;
                check("op_st_single", prev_st, 0);
                since = 0;
            end else since++;
            if (ack != 0) begin
                n_ack++;
                check("ack_onehot", $onehot(ack), 1);
                for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(ack[i]);
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_ack: ack=%b with nothing expected", ack);
                end else begin
                    e = sb.pop_front();
                    check("ack_idx", ack, 64'(1) << e.idx);
                    check("res_out", res_out, e.res);
                    check("err", err, e.err);
                    if (e.err) check("tmo_latency", since, TMO + 1);
                    else check("rd_to_ack", op_rd, 1);
                end
            end else if (err) check("err_outside_done", err, 0);
            prev_st = op_st;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin av[i] = '0; bv[i] = '0; ack_cnt[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_op_st", op_st, 0);
        check("rst_res", res_out, 0);
        check("rst_in0", op_in0, 0);
        check("rst_in1", op_in1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_ops(1, 1, 2);
        set_ops(2, 10, 20);
        run_batch(4'b0110, 2, "contention");

        set_ops(0, 4, 5);
        run_batch(4'b0001, 3, "single");

        for (int i = 0; i < NREQ; i++) begin set_ops(i, BW'(i + 1), BW'(10 * i)); ack_cnt[i] = 0; end
        dly_cfg = 2;
        for (int k = 0; k < 8; k++) push_exp(pick(4'hF, model_last), av[pick(4'hF, model_last)] + bv[pick(4'hF, model_last)], 1'b0);
        begin
            int got = 0, b = 2000;
            req = 4'hF;
            while ((req != 0 || busy) && b > 0) begin
                @(negedge clk);
                if (ack != 0) got++;
                if (got == 8) req = '0;
                b--;
            end
            check("fair_finished", b > 0, 1);
        end
        for (int i = 0; i < NREQ; i++) check("fair_count", ack_cnt[i], 2);

        set_ops(0, 16'h1234, 16'h0101);
        dly_cfg = 0;
        push_exp(0, '0, 1'b1);
        req = 4'b0001;
        wait_done("timeout");
        set_ops(1, 16'hfff0, 16'h0020);
        run_batch(4'b0010, 4, "after_tmo");

        set_ops(0, 4, 5);
        dly_cfg = 6;
        push_batch(4'b0001);
        req = 4'b0001;
        wait_st();
        repeat (2) @(negedge clk);
        a_bus[0 +: BW] = 16'd100;
        req = 4'b0000;
        wait_done("operand_change");

        set_ops(0, 3, 3);
        dly_cfg = 20;
        req = 4'b0001;
        wait_st();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        model_last = NREQ - 1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_res", res_out, 0);
        repeat (30) @(negedge clk);
        check("late_rd_ignored", busy, 0);
        set_ops(3, 7, 8);
        run_batch(4'b1000, 3, "after_reset");

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NREQ; i++) set_ops(i, BW'($urandom), BW'($urandom));
            run_batch(NREQ'($urandom_range(1, 15)), -1, "random");
        end
        repeat (3) @(negedge clk);
        check("st_per_ack", n_st, n_ack + 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/addition_scheduler.md
ADDITION_SCHEDULER -- requirements
Module: addition_scheduler

Interface
REQ-001 Parameter BW, 16, operand/result bit width of the shared operator.
REQ-002 Parameter NREQ, 4, number of requesters (2..8).
REQ-003 Parameter TMO, 64, maximum WAIT cycles before timeout (>=2).
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 REQ  in  NREQ  per-requester request level, held until its ACK.
REQ-007 A_BUS  in  NREQ*BW  requester i first operand at bits [i*BW +: BW].
REQ-008 B_BUS  in  NREQ*BW  requester i second operand, same packing.
REQ-009 ACK  out  NREQ  one-cycle completion pulse to granted requester.
REQ-010 RES_OUT  out  BW  result; valid in the ACK cycle, held until next ACK.
REQ-011 ERR  out  1  high with ACK when the transaction timed out.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 OP_ST  out  1  start pulse to shared operator.
REQ-014 OP_IN0, OP_IN1  out  BW each  operands to shared operator.
REQ-015 OP_RD  in  1  operator ready/done.
REQ-016 OP_RES  in  BW  operator result.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; registered state, one-hot or binary.
REQ-018 IDLE: if any REQ high, grant highest-priority requester, latch its A/B into OP_IN0/OP_IN1, go ISSUE; else stay.
REQ-019 Priority round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1 so requester 0 wins first.
REQ-020 ISSUE: OP_ST high for exactly this one cycle; next state WAIT; OP_RD ignored in ISSUE.
REQ-021 WAIT: first cycle OP_RD sampled high -> latch OP_RES into RES_OUT, ERR<=0, go DONE.
REQ-022 WAIT: timeout counter counts WAIT cycles; when it reaches TMO with no OP_RD -> RES_OUT<=0, ERR<=1, go DONE.
REQ-023 DONE: ACK[grant] high one cycle, ERR valid same cycle; next state IDLE; last_grant<=grant.
REQ-024 Latency: REQ seen in IDLE cycle n -> OP_ST cycle n+1 -> WAIT from n+2; OP_RD at cycle m -> ACK at m+1.
REQ-025 OP_IN0/OP_IN1 stable from ISSUE through DONE; requester operand changes after grant have no effect.
REQ-026 REQ deasserted after grant: transaction completes and ACK still pulses.
REQ-027 New grant earliest in the IDLE cycle following DONE; minimum 4 cycles per transaction; OP_ST never asserted outside ISSUE.
REQ-028 Arithmetic performed by the shared operator only; no width change, RES_OUT is OP_RES unmodified.
REQ-029 ACK is one-hot or zero; ERR is zero outside DONE.

Reset
REQ-030 RST low asynchronously forces IDLE, ACK=0, ERR=0, OP_ST=0, BUSY=0, RES_OUT=0, OP_IN0=OP_IN1=0, timeout counter=0, last_grant=NREQ-1.
REQ-031 Reset mid-transaction abandons it with no ACK; a late OP_RD after reset release is ignored in IDLE.
REQ-032 Reset release synchronous to CLK in the integrating design; first grant no earlier than first edge after release.

Structure
REQ-033 Shared package holds FSM state encoding constants and default BW/NREQ/TMO values.
REQ-034 One sub-module rr_arbiter (NREQ request vector + last_grant -> one-hot grant, index, valid), combinational.
REQ-035 Timeout counter width clog2(TMO+1); all logic in addition_scheduler plus rr_arbiter.

Verification
REQ-036 Single: REQ[0]=1, A0=4, B0=5, operator asserts RD 3 cycles after ST -> one OP_ST pulse, ACK[0] at RD+1, RES_OUT=9, ERR=0.
REQ-037 Contention: REQ[1]=REQ[2]=1 same cycle after reset, operands (1,2),(10,20) -> ACK[1] RES 3 first, then ACK[2] RES 30.
REQ-038 Fairness: all four REQ held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3, each ACK exactly twice.
REQ-039 Timeout: TMO=64, operator never asserts RD -> ACK at WAIT cycle 64 +1, ERR=1, RES_OUT=0, next request served normally.
REQ-040 Reset mid-WAIT: RST low 2 cycles while WAIT -> BUSY=0, no ACK, then REQ[3] (7+8) -> ACK[3], RES_OUT=15.
REQ-041 Operand change: A0 changed from 4 to 100 during WAIT -> RES_OUT still 9.
